// File: rtl/uart_tx_9600.sv
// uart_tx_9600: 8N1 UART transmitter with its own bit-period divider.
// Accepts a byte via start/ready handshake and shifts it out LSB first on tx.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit (8E1 framing).
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | line idle (tx=1), ready=1, waiting for start
// ST_START  | start bit (tx=0) for one bit period
// ST_DATA   | eight data bits, LSB first
// ST_PARITY | even parity bit (only with UART_TX_PARITY_EN)
// ST_STOP   | stop bit (tx=1), ready returns at its end
module uart_tx_9600 #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       start,
    output logic       ready,
    output logic       tx
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd4;
`endif

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             bit_end;
`ifdef UART_TX_PARITY_EN
    // Parity is captured at accept time because the shift register
    // no longer holds all eight bits by the time the parity bit is sent.
    logic             parity;
`endif

    // Last clock of the current bit period.
    always_comb begin
        bit_end = (cnt == CNT_LAST);
    end

    // Frame sequencer: bit timing, serial shift and handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
            ready   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    tx    <= 1'b1;
                    ready <= 1'b1;
                    if (start && ready) begin
                        shift <= data_in;
                        tx    <= 1'b0;
                        ready <= 1'b0;
                        cnt   <= '0;
                        state <= ST_START;
`ifdef UART_TX_PARITY_EN
                        parity <= ^data_in;
`endif
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        tx      <= shift[0];
                        bit_idx <= 3'd0;
                        state   <= ST_DATA;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx != 3'd7) begin
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end else begin
`ifdef UART_TX_PARITY_EN
                            tx    <= parity;
                            state <= ST_PARITY;
`else
                            tx    <= 1'b1;
                            state <= ST_STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        tx    <= 1'b1;
                        state <= ST_STOP;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        ready <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    tx    <= 1'b1;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_9600.sv
// Bench for uart_tx_9600 with CLKS_PER_BIT=4. The expected line level for
// every cycle of a frame comes from the frame layout (start, 8 data bits
// LSB first, optional even parity, stop), and each frame is also decoded
// independently by sampling mid-bit.
module tb_uart_tx_9600;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] data_in;
    logic       ready;
    logic       tx;

    int  total = 0;
    int  bad   = 0;
    time acc_time;
    logic [7:0]        last_dec;
    logic [FB*CPB-1:0] last_samp;

    uart_tx_9600 #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
        .clk    (clk),
        .reset  (reset),
        .data_in(data_in),
        .start  (start),
        .ready  (ready),
        .tx     (tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Line level of bit slot k of a frame carrying byte b.
    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_tx", tx, 1);
            check("idle_ready", ready, 1);
        end
    endtask

    // Send one byte. hold keeps start high afterwards; busy_n pulses start
    // with 0x3C at that frame cycle; rst_n asserts reset at that frame cycle.
    task automatic send(input logic [7:0] b, input bit hold, input int busy_n, input int rst_n);
        int waited;
        int low;
        logic [7:0] dec;
        waited = 0;
        low = 0;
        while (ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("ready_wait", ready, 1);
        data_in = b;
        start   = 1'b1;
        @(posedge clk);
        acc_time = $time;
        for (int n = 0; n < FB*CPB; n++) begin
            @(negedge clk);
            check("tx_bit", tx, exp_bit(b, n / CPB));
            check("ready_busy", ready, 0);
            if (ready === 1'b0) low++;
            last_samp[n] = tx;
            data_in = 8'($urandom);
            if (n == busy_n) begin
                start   = 1'b1;
                data_in = 8'h3C;
            end else if (!hold) begin
                start = 1'b0;
            end
            if (n == rst_n) begin
                reset = 1'b1;
                start = 1'b0;
                @(posedge clk);
                @(negedge clk);
                reset = 1'b0;
                check("rst_tx", tx, 1);
                check("rst_ready", ready, 1);
                return;
            end
        end
        @(negedge clk);
        check("ready_back", ready, 1);
        check("tx_after_stop", tx, 1);
        check("ready_low_cycles", low, FB*CPB);
        for (int i = 0; i < 8; i++) dec[i] = last_samp[CPB*(i+1) + CPB/2];
        check("decode", dec, b);
        last_dec = dec;
    endtask

    initial begin
        time t0;
        reset   = 1'b1;
        start   = 1'b0;
        data_in = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tx", tx, 1);
        check("reset_ready", ready, 1);
        reset = 1'b0;
        idle(50);

        send(8'hA5, 1'b0, -1, -1);
        idle(2);

        send(8'h00, 1'b1, -1, -1);
        t0 = acc_time;
        check("b2b_first", last_dec, 8'h00);
        send(8'hFF, 1'b0, -1, -1);
        check("b2b_gap", 32'((acc_time - t0) / 10), 41);
        check("b2b_second", last_dec, 8'hFF);
        idle(3);

        send(8'h55, 1'b0, 10, -1);
        idle(6);

        send(8'h81, 1'b0, -1, 17);
        idle(2);
        send(8'h81, 1'b0, -1, -1);
        idle(2);

`ifdef UART_TX_PARITY_EN
        send(8'h07, 1'b0, -1, -1);
        check("parity_07", last_samp[9*CPB + CPB/2], 1);
        idle(1);
        send(8'h03, 1'b0, -1, -1);
        check("parity_03", last_samp[9*CPB + CPB/2], 0);
        idle(1);
`endif

        for (int f = 0; f < 20; f++) begin
            logic [7:0] rb;
            idle(int'($urandom_range(0, 4)));
            rb = 8'($urandom);
            send(rb, 1'b0, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench timeout");
    end

endmodule
